// File: rtl/axis_packet_checker.sv
// AXI-Stream sink that checks an incrementing data sequence and fixed-length packet framing.
// It drives a registered tready with optional periodic backpressure and keeps sticky error flags and counters.
module axis_packet_checker #(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic              stall_en,
    input  logic              clear_err,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              err_data,
    output logic              err_last,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        stall_reg, stall_next;
    logic              tready_reg, tready_next;
    logic [DATA_W-1:0] exp_reg, exp_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  beat_reg, beat_next;
    logic [CNT_W-1:0]  pkt_reg, pkt_next;
    logic              err_data_reg, err_data_next;
    logic              err_last_reg, err_last_next;
    logic [7:0]        err_count_reg, err_count_next;

    logic accept;
    logic at_last;
    logic data_bad;
    logic last_bad;

    assign accept   = s_axis_tvalid && tready_reg;
    assign at_last  = (idx_reg == LAST_IDX);
    assign data_bad = accept && (s_axis_tdata != exp_reg);
    assign last_bad = accept && (s_axis_tlast != at_last);

    // Control: state, stall counter and the ready register derived from the next state.
    always_comb begin
        state_next  = state_reg;
        stall_next  = stall_reg;
        tready_next = 1'b0;
        state_next  = enable ? RUN : IDLE;
        if (!stall_en) begin
            stall_next = 2'd0;
        end else if (state_reg == RUN) begin
            stall_next = stall_reg + 2'd1;
        end
        tready_next = (state_next == RUN) && !(stall_en && (stall_next == 2'd3));
    end

    // Datapath: a same-cycle error beat wins over clear_err because it is applied afterwards.
    always_comb begin
        exp_next       = exp_reg;
        idx_next       = idx_reg;
        beat_next      = beat_reg;
        pkt_next       = pkt_reg;
        err_data_next  = err_data_reg;
        err_last_next  = err_last_reg;
        err_count_next = err_count_reg;
        if (clear_err) begin
            err_data_next  = 1'b0;
            err_last_next  = 1'b0;
            err_count_next = 8'd0;
        end
        if (accept) begin
            exp_next  = s_axis_tdata + DATA_W'(1);
            idx_next  = (s_axis_tlast || at_last) ? '0 : idx_reg + IDX_W'(1);
            beat_next = beat_reg + CNT_W'(1);
            if (s_axis_tlast) begin
                pkt_next = pkt_reg + CNT_W'(1);
            end
            if (data_bad) begin
                err_data_next = 1'b1;
            end
            if (last_bad) begin
                err_last_next = 1'b1;
            end
            if ((data_bad || last_bad) && (err_count_next != 8'hFF)) begin
                err_count_next = err_count_next + 8'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= IDLE;
            stall_reg     <= 2'd0;
            tready_reg    <= 1'b0;
            exp_reg       <= '0;
            idx_reg       <= '0;
            beat_reg      <= '0;
            pkt_reg       <= '0;
            err_data_reg  <= 1'b0;
            err_last_reg  <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            stall_reg     <= stall_next;
            tready_reg    <= tready_next;
            exp_reg       <= exp_next;
            idx_reg       <= idx_next;
            beat_reg      <= beat_next;
            pkt_reg       <= pkt_next;
            err_data_reg  <= err_data_next;
            err_last_reg  <= err_last_next;
            err_count_reg <= err_count_next;
        end
    end

    assign s_axis_tready = tready_reg;
    assign beat_count    = beat_reg;
    assign pkt_count     = pkt_reg;
    assign err_data      = err_data_reg;
    assign err_last      = err_last_reg;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_axis_packet_checker.sv
// Bench for axis_packet_checker: a queue-fed stream source plus a behavioural scoreboard.
// The scoreboard is compared every cycle, and directed scenarios pin literal results.
module tb_axis_packet_checker;

    localparam int PKT_LEN = 8;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic        stall_en = 1'b0;
    logic        clear_err;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [15:0] beat_count;
    logic [15:0] pkt_count;
    logic        err_data;
    logic        err_last;
    logic [7:0]  err_count;

    logic clr_manual = 1'b0;
    logic beat_clr = 1'b0;
    assign clear_err = clr_manual | beat_clr;

    always #5 aclk = ~aclk;

    axis_packet_checker #(.DATA_W(8), .PKT_LEN(PKT_LEN), .CNT_W(16)) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .stall_en(stall_en),
        .clear_err(clear_err), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .beat_count(beat_count),
        .pkt_count(pkt_count), .err_data(err_data), .err_last(err_last), .err_count(err_count)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       c;
    } beat_t;

    beat_t q[$];
    int    valid_pct = 100;
    int    checks = 0;
    int    errors = 0;
    logic  cmp_en = 1'b0;

    // Scoreboard state
    int m_exp = 0, m_idx = 0, m_beat = 0, m_pkt = 0, m_ec = 0;
    bit m_ed = 0, m_el = 0, m_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int d, input bit l, input bit c = 1'b0);
        beat_t b;
        b.d = d[7:0];
        b.l = l;
        b.c = c;
        q.push_back(b);
    endtask

    // Source: presents the queue head, with a random valid duty cycle.
    initial begin
        forever begin
            @(negedge aclk);
            if (q.size() > 0 && $urandom_range(99) < valid_pct) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = q[0].d;
                s_axis_tlast  = q[0].l;
                beat_clr      = q[0].c;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                beat_clr      = 1'b0;
            end
        end
    end

    // Behavioural model, updated from the handshake observed on each rising edge.
    always @(posedge aclk) begin
        bit acc, dbad, lbad;
        if (areset) begin
            m_exp = 0; m_idx = 0; m_beat = 0; m_pkt = 0; m_ec = 0;
            m_ed = 0; m_el = 0; m_run = 0;
        end else begin
            acc  = s_axis_tvalid && s_axis_tready;
            dbad = acc && (int'(s_axis_tdata) != m_exp);
            lbad = acc && (s_axis_tlast != (m_idx == PKT_LEN - 1));
            if (clear_err) begin
                m_ed = dbad;
                m_el = lbad;
                m_ec = (dbad || lbad) ? 1 : 0;
            end else begin
                m_ed = m_ed || dbad;
                m_el = m_el || lbad;
                if ((dbad || lbad) && m_ec < 255) m_ec = m_ec + 1;
            end
            if (acc) begin
                m_exp  = (int'(s_axis_tdata) + 1) % 256;
                m_idx  = (s_axis_tlast || m_idx == PKT_LEN - 1) ? 0 : m_idx + 1;
                m_beat = (m_beat + 1) % 65536;
                if (s_axis_tlast) m_pkt = (m_pkt + 1) % 65536;
                if (q.size() > 0) void'(q.pop_front());
            end
            m_run = enable;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge aclk) begin
        if (cmp_en) begin
            chk("beat_count", beat_count, m_beat);
            chk("pkt_count", pkt_count, m_pkt);
            chk("err_data", err_data, m_ed);
            chk("err_last", err_last, m_el);
            chk("err_count", err_count, m_ec);
            if (!m_run) chk("tready_idle", s_axis_tready, 0);
        end
    end

    task automatic do_reset();
        @(negedge aclk);
        #1;
        areset = 1'b1; enable = 1'b0; stall_en = 1'b0; clr_manual = 1'b0;
        valid_pct = 100;
        q.delete();
        repeat (2) @(negedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        repeat (2) @(negedge aclk);
    endtask

    task automatic chk_all(input string tag, input int bc, input int pc, input int ed,
                           input int el, input int ec);
        chk({tag, "_beats"}, beat_count, bc);
        chk({tag, "_pkts"}, pkt_count, pc);
        chk({tag, "_err_data"}, err_data, ed);
        chk({tag, "_err_last"}, err_last, el);
        chk({tag, "_err_count"}, err_count, ec);
        $display("scenario %s: beats=%0d pkts=%0d err_data=%0d err_last=%0d err_count=%0d",
                 tag, beat_count, pkt_count, err_data, err_last, err_count);
    endtask

    initial begin
        int gen_d, g_idx, cyc, d;
        bit l;

        // Reset state
        do_reset();
        cmp_en = 1'b1;
        @(negedge aclk);
        chk("reset_tready", s_axis_tready, 0);
        chk_all("reset", 0, 0, 0, 0, 0);

        // Long clean stream with data wrap
        #1;
        enable = 1'b1;
        for (int i = 0; i < 2060; i++) push(i % 256, (i % 8) == 7);
        drain(5000);
        chk_all("long_stream", 2060, 257, 0, 0, 0);

        // Periodic backpressure: ready low on every 4th RUN cycle
        do_reset();
        stall_en = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) push(i, (i % 8) == 7);
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            chk("stall_pattern", s_axis_tready, (k % 4) != 3);
        end
        drain(500);
        chk_all("stall", 100, 12, 0, 0, 0);

        // Single data error resynchronises
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 16; i++) push(i < 5 ? i : i + 2, (i % 8) == 7);
        drain(200);
        chk_all("data_err", 16, 2, 1, 0, 1);

        // Early tlast followed by a clean packet
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push(i, i == 3);
        for (int i = 0; i < 8; i++) push(4 + i, i == 7);
        drain(200);
        chk_all("early_last", 12, 2, 0, 1, 1);

        // Enable gap mid-packet, then clear handling
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push(i, 1'b0);
        drain(200);
        #1;
        enable = 1'b0;
        repeat (10) begin
            @(negedge aclk);
            chk("gap_tready", s_axis_tready, 0);
        end
        #1;
        enable = 1'b1;
        for (int i = 4; i < 8; i++) push(i, i == 7);
        drain(200);
        chk_all("resume", 8, 1, 0, 0, 0);
        #1;
        push(8'h55, 1'b0);
        push(8'h77, 1'b0);
        drain(200);
        chk_all("two_errs", 10, 1, 1, 0, 2);
        #1;
        clr_manual = 1'b1;
        @(negedge aclk);
        #1;
        clr_manual = 1'b0;
        chk_all("cleared", 10, 1, 0, 0, 0);
        push(8'h10, 1'b0);
        push(8'h30, 1'b0);
        push(8'h50, 1'b0, 1'b1);
        drain(200);
        chk_all("clear_vs_err", 13, 1, 1, 0, 1);

        // Reset mid-packet, then a fresh stream
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) push(i, i == 7);
        cyc = 0;
        while (beat_count != 16'd3 && cyc < 200) begin
            @(negedge aclk);
            cyc++;
        end
        chk("mid_reset_reach", beat_count, 3);
        #1;
        areset = 1'b1;
        @(negedge aclk);
        chk("mid_reset_tready", s_axis_tready, 0);
        chk_all("mid_reset", 0, 0, 0, 0, 0);
        #1;
        areset = 1'b0;
        q.delete();
        for (int i = 0; i < 16; i++) push(i, (i % 8) == 7);
        drain(200);
        chk_all("after_reset", 16, 2, 0, 0, 0);

        // Randomized traffic with errors, backpressure, gaps and clears
        do_reset();
        enable = 1'b1;
        valid_pct = 70;
        gen_d = 0;
        g_idx = 0;
        for (int i = 0; i < 1500; i++) begin
            d = gen_d % 256;
            if ($urandom_range(99) < 20) d = int'($urandom_range(255));
            l = (g_idx == PKT_LEN - 1);
            if ($urandom_range(99) < 8) l = !l;
            push(d, l);
            gen_d = d + 1;
            g_idx = (l || g_idx == PKT_LEN - 1) ? 0 : g_idx + 1;
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 20000) begin
            @(negedge aclk);
            #1;
            if (cyc % 8 == 0) enable = ($urandom_range(99) < 85);
            if ($urandom_range(99) < 5) stall_en = !stall_en;
            clr_manual = (cyc < 300) && ($urandom_range(99) < 2);
            cyc++;
        end
        clr_manual = 1'b0;
        enable = 1'b1;
        chk("random_timeout", q.size(), 0);
        repeat (3) @(negedge aclk);
        chk("random_beats", beat_count, 1500);
        chk("random_saturate", err_count, 255);
        $display("scenario random: beats=%0d pkts=%0d err_count=%0d cycles=%0d",
                 beat_count, pkt_count, err_count, cyc);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
